// File: rtl/fir_decim_requant.sv
// fir_decim_requant
//   Sits after the FIR filter: keeps one sample out of every DECIM accepted
//   beats (or the last partial window of a frame), rounds and saturates it
//   from IN_W to OUT_W signed bits, and hands it to the sink through a
//   2-entry in-order skid buffer so both sides can stream at one beat/cycle.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   s_axis_tdata   signed sample from the FIR (IN_W)
//   s_axis_tvalid  input valid
//   s_axis_tlast   last beat of frame; flushes a partial window
//   s_axis_tready  registered: skid buffer holds fewer than 2 entries
//   m_axis_tdata   requantized signed sample (OUT_W)
//   m_axis_tvalid  skid buffer not empty
//   m_axis_tlast   frame boundary carried with the sample
//   m_axis_tready  downstream ready
//   sat_flag       sticky saturation indicator
//   sat_clr        synchronous clear of sat_flag (a coincident set wins)
module fir_decim_requant #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int DECIM = 4,
  parameter int SHIFT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic             sat_flag,
  input  logic             sat_clr
);

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

  // Rounding offset and saturation bounds, all in the IN_W+1-bit domain.
  localparam logic signed [IN_W:0] RND     = (IN_W+1)'(64'(1) << (SHIFT - 1));
  localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'((64'(1) << (OUT_W - 1)) - 64'(1));
  localparam logic signed [IN_W:0] SAT_MIN = ~SAT_MAX;
  localparam logic [OUT_W-1:0]     OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]     OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic [PH_W-1:0]        phase;
  logic                   accept;
  logic                   emit_beat;
  logic                   push;
  logic                   pop;

  logic signed [IN_W:0]   x_ext;
  logic signed [IN_W:0]   sum;
  logic signed [IN_W:0]   r;
  logic [OUT_W-1:0]       q;
  logic                   sat;

  logic [1:0]             occ;
  logic [1:0]             occ_next;
  logic [OUT_W-1:0]       head_data;
  logic                   head_last;
  logic [OUT_W-1:0]       tail_data;
  logic                   tail_last;

  assign accept    = s_axis_tvalid && s_axis_tready;
  assign emit_beat = (phase == PH_LAST) || s_axis_tlast;
  assign push      = accept && emit_beat;
  assign pop       = m_axis_tvalid && m_axis_tready;

  // Round half toward +inf, then arithmetic shift; one extra bit keeps the
  // rounding add from overflowing at the positive extreme.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    x_ext = $signed({s_axis_tdata[IN_W-1], s_axis_tdata});
    sum   = x_ext + RND;
    r     = sum >>> SHIFT;
    q     = r[OUT_W-1:0];
    sat   = 1'b0;
    if (r > SAT_MAX) begin
      q   = OUT_MAX;
      sat = 1'b1;
    end else if (r < SAT_MIN) begin
      q   = OUT_MIN;
      sat = 1'b1;
    end
  end

  // Phase returns to 0 on every emit, so a tlast flush realigns the next
  // frame to a fresh window.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (accept) begin
      phase <= emit_beat ? '0 : phase + 1'b1;
    end
  end

  always_comb begin
    occ_next = occ;
    unique case ({push, pop})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  // Head entry drives the output and only changes on pop or on a push into
  // an empty (or simultaneously draining) buffer, so it is stable while
  // stalled. tready is registered from the next occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ           <= 2'd0;
      s_axis_tready <= 1'b0;
      head_data     <= '0;
      head_last     <= 1'b0;
    end else begin
      occ           <= occ_next;
      s_axis_tready <= (occ_next != 2'd2);
      if (push && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
        head_data <= q;
        head_last <= s_axis_tlast;
      end else if (pop && (occ == 2'd2)) begin
        head_data <= tail_data;
        head_last <= tail_last;
      end
    end
  end

  // NOTE: the tail payload is left unreset; it is read only at occupancy 2,
  // which can only be reached by writing it first.
  always_ff @(posedge clk) begin
    if (push && (occ == 2'd1) && !pop) begin
      tail_data <= q;
      tail_last <= s_axis_tlast;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag <= 1'b0;
    end else if (push && sat) begin
      sat_flag <= 1'b1;
    end else if (sat_clr) begin
      sat_flag <= 1'b0;
    end
  end

  assign m_axis_tvalid = (occ != 2'd0);
  assign m_axis_tdata  = head_data;
  assign m_axis_tlast  = head_last;

endmodule

// File: tb/tb_fir_decim_requant.sv
// Directed bench for fir_decim_requant. Two instances share stimulus: u_d4
// (DECIM=4) and u_d1 (DECIM=1); sel routes tvalid to one and muxes its
// outputs back. Inputs change and outputs are sampled on the falling edge.
module tb_fir_decim_requant;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        m_tready;
  logic        sat_clr;

  logic        rdy4, rdy1, mv4, mv1, ml4, ml1, sat4, sat1;
  logic [15:0] md4, md1;

  logic        s_tready_s, m_tvalid_s, m_tlast_s, sat_s;
  logic [15:0] m_tdata_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fir_decim_requant #(.IN_W(32), .OUT_W(16), .DECIM(4), .SHIFT(15)) u_d4 (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid && !sel), .s_axis_tlast(s_tlast),
    .s_axis_tready(rdy4),
    .m_axis_tdata(md4), .m_axis_tvalid(mv4), .m_axis_tlast(ml4), .m_axis_tready(m_tready),
    .sat_flag(sat4), .sat_clr(sat_clr)
  );

  fir_decim_requant #(.IN_W(32), .OUT_W(16), .DECIM(1), .SHIFT(15)) u_d1 (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid && sel), .s_axis_tlast(s_tlast),
    .s_axis_tready(rdy1),
    .m_axis_tdata(md1), .m_axis_tvalid(mv1), .m_axis_tlast(ml1), .m_axis_tready(m_tready),
    .sat_flag(sat1), .sat_clr(sat_clr)
  );

  assign s_tready_s = sel ? rdy1 : rdy4;
  assign m_tvalid_s = sel ? mv1  : mv4;
  assign m_tlast_s  = sel ? ml1  : ml4;
  assign m_tdata_s  = sel ? md1  : md4;
  assign sat_s      = sel ? sat1 : sat4;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic push(input logic [31:0] d, input logic l);
    int waited = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    while (!s_tready_s && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!s_tready_s) check("push_ready_timeout", {31'b0, s_tready_s}, 1);
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k, e, last_pop;
    logic do_pop, do_acc;

    reset = 1'b0; sel = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b1; sat_clr = 1'b0;

    // Reset state
    #1;
    check("rst_m_tvalid", {31'b0, mv4}, 0);
    check("rst_m_tdata", $signed(md4), 0);
    check("rst_m_tlast", {31'b0, ml4}, 0);
    check("rst_sat_flag", {31'b0, sat4}, 0);
    repeat (3) @(negedge clk);
    check("rst_s_tready_held", {31'b0, rdy4}, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_s_tready_release", {31'b0, rdy4}, 1);

    // Decimation by 4: only the 4th beat survives
    push(32'd98304, 1'b0);
    check("dec_drop1", {31'b0, m_tvalid_s}, 0);
    push(32'd1, 1'b0);
    check("dec_drop2", {31'b0, m_tvalid_s}, 0);
    push(32'd2, 1'b0);
    check("dec_drop3", {31'b0, m_tvalid_s}, 0);
    push(32'd163840, 1'b0);
    check("dec_out_valid", {31'b0, m_tvalid_s}, 1);
    check("dec_out_data", $signed(m_tdata_s), 5);
    check("dec_out_last", {31'b0, m_tlast_s}, 0);
    @(negedge clk);
    check("dec_drained", {31'b0, m_tvalid_s}, 0);

    // Rounding, DECIM=1
    sel = 1'b1;
    push(32'd16384, 1'b0);
    check("rnd_p16384", $signed(m_tdata_s), 1);
    push(-32'sd16384, 1'b0);
    check("rnd_m16384", $signed(m_tdata_s), 0);
    push(-32'sd16385, 1'b0);
    check("rnd_m16385", $signed(m_tdata_s), -1);
    push(32'd49151, 1'b0);
    check("rnd_p49151", $signed(m_tdata_s), 1);
    check("rnd_no_sat", {31'b0, sat_s}, 0);

    // Saturation and sticky flag
    push(32'h7FFF_FFFF, 1'b0);
    check("sat_pos_data", $signed(m_tdata_s), 32767);
    check("sat_pos_flag", {31'b0, sat_s}, 1);
    push(32'h8000_0000, 1'b0);
    check("sat_neg_data", $signed(m_tdata_s), -32768);
    check("sat_neg_flag", {31'b0, sat_s}, 1);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    check("sat_clr", {31'b0, sat_s}, 0);
    sat_clr = 1'b1;
    push(32'h7FFF_FFFF, 1'b0);
    sat_clr = 1'b0;
    check("sat_set_wins", {31'b0, sat_s}, 1);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    check("sat_clr2", {31'b0, sat_s}, 0);
    @(negedge clk);

    // Partial frame flush and phase realignment, DECIM=4
    sel = 1'b0;
    push(32'd32768, 1'b0);
    push(32'd65536, 1'b0);
    push(32'd98304, 1'b0);
    push(32'd131072, 1'b0);
    check("pf_beat4_data", $signed(m_tdata_s), 4);
    check("pf_beat4_last", {31'b0, m_tlast_s}, 0);
    push(32'd163840, 1'b0);
    check("pf_beat5_drop", {31'b0, m_tvalid_s}, 0);
    push(32'd196608, 1'b1);
    check("pf_beat6_valid", {31'b0, m_tvalid_s}, 1);
    check("pf_beat6_data", $signed(m_tdata_s), 6);
    check("pf_beat6_last", {31'b0, m_tlast_s}, 1);
    push(32'd229376, 1'b0);
    push(32'd262144, 1'b0);
    push(32'd294912, 1'b0);
    check("pf_next_drop3", {31'b0, m_tvalid_s}, 0);
    push(32'd327680, 1'b0);
    check("pf_next_data", $signed(m_tdata_s), 10);
    check("pf_next_last", {31'b0, m_tlast_s}, 0);
    @(negedge clk);

    // Backpressure, DECIM=1: stall 5 cycles with continuous input
    sel = 1'b1;
    k = 1; e = 1; last_pop = -1;
    s_tdata = 32'(k * 32768);
    s_tvalid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      m_tready = (c >= 5);
      if (c >= 2 && c <= 4) begin
        check("bp_stall_ready", {31'b0, s_tready_s}, 0);
        check("bp_hold_data", $signed(m_tdata_s), 1);
      end
      do_pop = m_tvalid_s && m_tready;
      if (do_pop) begin
        check("bp_order", $signed(m_tdata_s), e);
        e++;
        last_pop = c;
      end
      do_acc = s_tvalid && s_tready_s;
      @(negedge clk);
      if (do_acc) begin
        k++;
        if (k > 8) s_tvalid = 1'b0;
        else       s_tdata  = 32'(k * 32768);
      end
    end
    check("bp_count", e, 9);
    check("bp_last_pop_cycle", last_pop, 12);
    check("bp_empty", {31'b0, m_tvalid_s}, 0);

    // Async reset mid-stream
    sel = 1'b0;
    m_tready = 1'b1;
    push(32'd32768, 1'b0);
    push(32'd32768, 1'b0);
    sel = 1'b1;
    m_tready = 1'b0;
    push(32'd655360, 1'b0);
    push(32'd688128, 1'b0);
    check("ar_buffered_valid", {31'b0, m_tvalid_s}, 1);
    check("ar_buffered_data", $signed(m_tdata_s), 20);
    #2 reset = 1'b0;
    #1;
    check("ar_valid_async", {31'b0, m_tvalid_s}, 0);
    check("ar_ready_async", {31'b0, s_tready_s}, 0);
    @(negedge clk);
    reset = 1'b1;
    m_tready = 1'b1;
    @(negedge clk);
    check("ar_ready_release", {31'b0, s_tready_s}, 1);
    check("ar_no_stale1", {31'b0, m_tvalid_s}, 0);
    @(negedge clk);
    check("ar_no_stale2", {31'b0, m_tvalid_s}, 0);
    sel = 1'b0;
    push(32'd32768, 1'b0);
    push(32'd65536, 1'b0);
    push(32'd98304, 1'b0);
    check("ar_phase_drop3", {31'b0, m_tvalid_s}, 0);
    push(32'd229376, 1'b0);
    check("ar_phase_valid", {31'b0, m_tvalid_s}, 1);
    check("ar_phase_data", $signed(m_tdata_s), 7);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
